// File: rtl/mem_line_engine_pkg.sv
// Shared types, default geometry and line-packing helper for the memory
// line-transfer engine.
package mem_line_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_WORDS  = 4;
  localparam int OFF_W      = $clog2(DEF_WORDS);
  localparam int LINE_W     = DEF_ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Bit offset of word idx inside a packed line of width-bit words.
  function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mem_line_engine.sv
// Line-transfer initiator: turns one refill/writeback line request into
// consecutive single-word accesses on a word-wide memory bank.
module mem_line_engine
  import mem_line_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORDS  = DEF_WORDS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [ADDR_W-$clog2(WORDS)-1:0]     req_line,
  input  logic [WORDS*DATA_W-1:0]             req_wdata,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic                                rsp_write,
  output logic [WORDS*DATA_W-1:0]             rsp_rdata,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic                                mem_write_en,
  output logic [DATA_W-1:0]                   mem_wdata,
  input  logic [DATA_W-1:0]                   mem_rdata
);

  localparam int CNT_W  = $clog2(WORDS);
  localparam int LN_W   = ADDR_W - CNT_W;
  localparam int LINE_BITS = WORDS * DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  state_e                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [LN_W-1:0]        line_r;
  logic                   write_r;
  logic [LINE_BITS-1:0]   wdata_r;
  logic [LINE_BITS-1:0]   rdata_r;

  logic                   busy_s;
  int unsigned            lsb_s;
  logic [LINE_BITS-1:0]   word_mask_s;
  logic [LINE_BITS-1:0]   rdata_ins_s;
  logic [DATA_W-1:0]      wword_s;

  // Word selection for the current counter position, both directions.
  always_comb begin
    busy_s      = (state_r == READ) || (state_r == WRITE);
    lsb_s       = word_lsb(32'(cnt_r), 32'(DATA_W));
    word_mask_s = {{((WORDS-1)*DATA_W){1'b0}}, {DATA_W{1'b1}}} << lsb_s;
    rdata_ins_s = {{((WORDS-1)*DATA_W){1'b0}}, mem_rdata} << lsb_s;
    wword_s     = DATA_W'(wdata_r >> lsb_s);
  end

  // Sequencer: latch a request, walk the line one word per cycle, then hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      line_r  <= {LN_W{1'b0}};
      write_r <= 1'b0;
      wdata_r <= {LINE_BITS{1'b0}};
      rdata_r <= {LINE_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            line_r  <= req_line;
            write_r <= req_write;
            wdata_r <= req_wdata;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= req_write ? WRITE : READ;
          end
        end
        READ: begin
          // Bank read is combinational, so the word is captured in the cycle its address is driven.
          rdata_r <= (rdata_r & ~word_mask_s) | rdata_ins_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= RESP;
          end
        end
        WRITE: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Handshake and bank-port decode; ready and write strobe are killed while rst is high.
  always_comb begin
    req_ready    = (state_r == IDLE) && !rst;
    rsp_valid    = (state_r == RESP);
    mem_write_en = (state_r == WRITE) && !rst;
    if (busy_s) begin
      mem_addr = {line_r, cnt_r};
    end else begin
      mem_addr = {ADDR_W{1'b0}};
    end
    if (state_r == WRITE) begin
      mem_wdata = wword_s;
    end else begin
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  assign rsp_write = write_r;
  assign rsp_rdata = rdata_r;

endmodule

// File: tb/tb_mem_line_engine.sv
// Scoreboard bench for mem_line_engine: driver queues expected responses and
// bank writes, a negedge monitor pops and compares them.
module tb_mem_line_engine;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int LINE_W = 26;

  localparam logic [127:0] LINE_A   = 128'h000000D0_000000C0_000000B0_000000A0;
  localparam logic [127:0] LINE_W1  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_TOP = 128'h70000003_70000002_70000001_70000000;
  localparam logic [127:0] LINE_E   = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
  localparam logic [127:0] LINE_AE  = 128'h000000D0_000000C0_EEEE0001_EEEE0000;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [LINE_W-1:0]   req_line;
  logic [127:0]        req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_write;
  logic [127:0]        rsp_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_write_en;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  always #5 clk = ~clk;

  mem_line_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_line(req_line), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Bank model: words 0..7 and the top line are backed, the rest return an address tag.
  logic [31:0] bank_lo [0:7];
  logic [31:0] bank_hi [0:3];
  logic        bank_init;

  always_comb begin
    if (mem_addr < 28'd8) mem_rdata = bank_lo[mem_addr[2:0]];
    else if (mem_addr >= 28'hFFFFFFC) mem_rdata = bank_hi[mem_addr[1:0]];
    else mem_rdata = {4'h9, mem_addr};
  end

  always @(posedge clk) begin
    if (bank_init) begin
      bank_lo[0] <= 32'hA0; bank_lo[1] <= 32'hB0; bank_lo[2] <= 32'hC0; bank_lo[3] <= 32'hD0;
      for (int i = 4; i < 8; i++) bank_lo[i] <= 32'h0;
      for (int i = 0; i < 4; i++) bank_hi[i] <= 32'h70000000 + 32'(i);
    end else if (mem_write_en) begin
      if (mem_addr < 28'd8) bank_lo[mem_addr[2:0]] <= mem_wdata;
      else if (mem_addr >= 28'hFFFFFFC) bank_hi[mem_addr[1:0]] <= mem_wdata;
    end
  end

  // Scoreboard queues
  logic          ex_w [$];
  logic [127:0]  ex_d [$];
  logic [27:0]   wq_addr [$];
  logic [31:0]   wq_data [$];
  string         dq_name [$];
  logic [127:0]  dq_act [$];
  logic [127:0]  dq_exp [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic rsp_valid_d = 1'b0;
  logic m_w;
  logic [127:0] m_d;
  logic [127:0] last_refill;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT output with no expectation queued (t=%0t)", nm, $time);
  endtask

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    while (dq_name.size() > 0) cmp(dq_name.pop_front(), dq_act.pop_front(), dq_exp.pop_front());
    if (!rst) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (rsp_valid && !rsp_valid_d) cmp("rsp_latency", 128'(cyc - acc_cyc), 128'(WORDS + 1));
      if (rsp_valid && rsp_ready) begin
        if (ex_w.size() == 0) miss("unexpected_rsp");
        else begin
          m_w = ex_w.pop_front();
          m_d = ex_d.pop_front();
          cmp("rsp_write", 128'(rsp_write), 128'(m_w));
          cmp("rsp_rdata", rsp_rdata, m_d);
        end
      end
      if (mem_write_en) begin
        if (wq_addr.size() == 0) miss("unexpected_write");
        else begin
          cmp("wr_addr", 128'(mem_addr), 128'(wq_addr.pop_front()));
          cmp("wr_data", 128'(mem_wdata), 128'(wq_data.pop_front()));
        end
      end
    end
    rsp_valid_d = rsp_valid;
  end

  task automatic dchk(input string nm, input logic [127:0] a, input logic [127:0] e);
    dq_name.push_back(nm);
    dq_act.push_back(a);
    dq_exp.push_back(e);
  endtask

  task automatic start_req(input logic wr, input logic [LINE_W-1:0] line, input logic [127:0] wdata,
                           input logic [127:0] rexp, input logic push_rsp, input int nwr);
    logic [1:0] kk;
    req_write = wr;
    req_line  = line;
    req_wdata = wdata;
    req_valid = 1'b1;
    if (push_rsp) begin
      ex_w.push_back(wr);
      ex_d.push_back(wr ? last_refill : rexp);
      if (!wr) last_refill = rexp;
    end
    for (int k = 0; k < nwr; k++) begin
      kk = 2'(k);
      wq_addr.push_back({line, kk});
      wq_data.push_back(wdata[k*32 +: 32]);
    end
  endtask

  task automatic wait_accept();
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      n++;
    end
    if (!ok) dchk("accept_timeout", 128'(req_ready), 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((ex_w.size() != 0 || wq_addr.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) dchk("drain_rsp_left", 128'(ex_w.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, 3);
    repeat (g) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n;
    logic [127:0] wd;
    rst = 1'b1; bank_init = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_line = '0; req_wdata = '0; rsp_ready = 1'b1; last_refill = '0;

    // Refill request held through reset
    start_req(1'b0, 26'd0, 128'd0, LINE_A, 1'b1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    dchk("rst_req_ready", 128'(req_ready), 128'd0);
    dchk("rst_mem_we", 128'(mem_write_en), 128'd0);
    dchk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    dchk("rst_mem_addr", 128'(mem_addr), 128'd0);
    dchk("rst_rsp_rdata", rsp_rdata, 128'd0);
    dchk("rst_rsp_write", 128'(rsp_write), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0; bank_init = 1'b0;
    wait_accept();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dchk("refill_addr", 128'(mem_addr), 128'(k));
    end
    drain();

    // Writeback line 1, then refill it back
    start_req(1'b1, 26'd1, LINE_W1, 128'd0, 1'b1, 4);
    wait_accept();
    drain();
    start_req(1'b0, 26'd1, 128'd0, LINE_W1, 1'b1, 0);
    wait_accept();
    drain();

    // Back-pressure with the next (top-line) request held
    rsp_ready = 1'b0;
    start_req(1'b0, 26'd0, 128'd0, LINE_A, 1'b1, 0);
    wait_accept();
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    dchk("bp_rsp_valid_seen", 128'(rsp_valid), 128'd1);
    start_req(1'b0, 26'h3FFFFFF, 128'd0, LINE_TOP, 1'b1, 0);
    repeat (10) begin
      @(negedge clk);
      dchk("bp_rsp_valid", 128'(rsp_valid), 128'd1);
      dchk("bp_rsp_rdata", rsp_rdata, LINE_A);
      dchk("bp_req_ready", 128'(req_ready), 128'd0);
      dchk("bp_mem_we", 128'(mem_write_en), 128'd0);
      dchk("bp_mem_addr", 128'(mem_addr), 128'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    dchk("hs_req_ready_resp", 128'(req_ready), 128'd0);
    @(negedge clk);
    dchk("hs_req_ready_idle", 128'(req_ready), 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    dchk("top_addr0", 128'(mem_addr), 128'h0FFFFFFC);
    dchk("top_req_ready", 128'(req_ready), 128'd0);
    @(negedge clk);
    dchk("top_addr1", 128'(mem_addr), 128'h0FFFFFFD);
    drain();

    // Reset during word 2 of a writeback to line 0
    start_req(1'b1, 26'd0, LINE_E, 128'd0, 1'b0, 2);
    wait_accept();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    dchk("midrst_mem_we", 128'(mem_write_en), 128'd0);
    dchk("midrst_req_ready", 128'(req_ready), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_refill = '0;
    @(negedge clk);
    dchk("post_rst_rsp_valid", 128'(rsp_valid), 128'd0);
    dchk("post_rst_rsp_rdata", rsp_rdata, 128'd0);
    dchk("post_rst_rsp_write", 128'(rsp_write), 128'd0);
    dchk("post_rst_mem_addr", 128'(mem_addr), 128'd0);
    dchk("post_rst_mem_we", 128'(mem_write_en), 128'd0);
    dchk("post_rst_mem_wdata", 128'(mem_wdata), 128'd0);
    dchk("post_rst_req_ready", 128'(req_ready), 128'd1);
    dchk("post_rst_wq_left", 128'(wq_addr.size()), 128'd0);
    @(posedge clk); #1;
    start_req(1'b0, 26'd0, 128'd0, LINE_AE, 1'b1, 0);
    wait_accept();
    drain();

    // Alternating writeback/refill of line 1 with random gaps
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 4; j++) wd[j*32 +: 32] = 32'hC0DE0000 | 32'(p * 16 + j);
      start_req(1'b1, 26'd1, wd, 128'd0, 1'b1, 4);
      wait_accept();
      gap();
      start_req(1'b0, 26'd1, 128'd0, wd, 1'b1, 0);
      wait_accept();
      gap();
    end
    drain();

    dchk("end_rsp_left", 128'(ex_w.size()), 128'd0);
    dchk("end_wq_left", 128'(wq_addr.size()), 128'd0);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
